// File: rtl/midi_tx_queue_if.sv
// Push-side and uart_tx-side signals of the MIDI OUT transmit queue.
// The master modport is the router/uart_tx environment, the slave modport is the queue.
interface midi_tx_queue_if #(
  parameter int unsigned AW = 4
) ();

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          tx_strobe;
  logic [7:0]    tx_data;
  logic          tx_busy;

  modport master (
    output wr_en, wr_data, flush, tx_busy,
    input  full, empty, count, overflow, tx_strobe, tx_data
  );

  modport slave (
    input  wr_en, wr_data, flush, tx_busy,
    output full, empty, count, overflow, tx_strobe, tx_data
  );

endinterface

// File: rtl/midi_tx_queue.sv
// MIDI OUT transmit queue: buffers router bytes in a DEPTH-entry FIFO and issues them to
// uart_tx one frame at a time, strobing the next byte only once the previous frame is done.
module midi_tx_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  midi_tx_queue_if.slave bus
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStrobe, StWaitBusy, StWaitDone} state_e;

  state_e        state_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          strobe_q;
  logic [7:0]    data_q;
  logic [1:0]    tmo_q;
  logic          push;
  logic          pop;

  // Push/pop qualification; flush wins over both so a cleared queue never issues a stale byte.
  always_comb begin
    push = bus.wr_en && !full_q && !bus.flush;
    pop  = (state_q == StIdle) && !empty_q && !bus.tx_busy && !bus.flush;
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; no reset needed since entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Pointers, occupancy flags and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == DepthCnt);
      empty_q <= (count_d == '0);
      // Full is judged on the registered flag, so a pop in the same cycle does not save the byte.
      if (bus.wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Issue sequencer with registered strobe/data; WAIT_BUSY times out in case uart_tx missed the load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      strobe_q <= 1'b0;
      data_q   <= 8'h00;
      tmo_q    <= 2'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            data_q   <= mem[rd_ptr_q];
            strobe_q <= 1'b1;
            state_q  <= StStrobe;
          end
        end
        StStrobe: begin
          strobe_q <= 1'b0;
          tmo_q    <= 2'd0;
          state_q  <= StWaitBusy;
        end
        StWaitBusy: begin
          if (bus.tx_busy) begin
            state_q <= StWaitDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == 2'd3) begin
              state_q <= StIdle;
            end
          end
        end
        StWaitDone: begin
          if (!bus.tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.tx_strobe = strobe_q;
  assign bus.tx_data   = data_q;

endmodule
